// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: keeps the program counter, issues one instruction fetch at a time and hands the word to decode.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and sets fetch_misaligned.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_resolve,
    input  logic        pc_input_sel,
    input  logic [31:0] alu_result,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_t;

    typedef enum logic {
        PC_INPUT_PC_PLUS_4 = 1'b0,
        PC_INPUT_ALU       = 1'b1
    } pc_input_sel_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         misaligned_q, misaligned_d;
    logic         req_valid_q, req_valid_d;
    logic         instr_valid_q, instr_valid_d;

    logic         redirect_s;
    logic         target_bad_s;
    logic         handshake_s;
    logic [31:0]  target_s;

    // Redirect decode and target legalisation
    always_comb begin
        redirect_s  = branch_resolve && (pc_input_sel_t'(pc_input_sel) == PC_INPUT_ALU);
        handshake_s = req_valid_q && imem_req_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
        target_s     = alu_result;
        target_bad_s = redirect_s && (alu_result[1:0] != 2'b00);
`else
        target_s     = alu_result & 32'hFFFF_FFFC;
        target_bad_s = 1'b0;
`endif
    end

    // Next-state, PC and capture logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        misaligned_d = misaligned_q;
        if ((state_q != FETCH_HALT) && target_bad_s) begin
            state_d      = FETCH_HALT;
            misaligned_d = 1'b1;
            kill_d       = 1'b0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (redirect_s) pc_d = target_s;
                    else            pc_d = pc_q;
                    // A redirect racing the handshake leaves a stale request in flight
                    if (handshake_s) begin
                        state_d = FETCH_WAIT;
                        kill_d  = redirect_s;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q || redirect_s) begin
                            kill_d  = 1'b0;
                            state_d = FETCH_REQ;
                            if (redirect_s) pc_d = target_s;
                            else            pc_d = pc_q;
                        end else begin
                            instr_d    = imem_rsp_data;
                            instr_pc_d = pc_q;
                            state_d    = FETCH_HOLD;
                        end
                    end else if (redirect_s) begin
                        kill_d = 1'b1;
                        pc_d   = target_s;
                    end else begin
                        kill_d = kill_q;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_s) begin
                        pc_d    = target_s;
                        state_d = FETCH_REQ;
                    end else if (instr_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH_REQ;
                    end else begin
                        state_d = FETCH_HOLD;
                    end
                end
                FETCH_HALT: state_d = FETCH_HALT;
                default:    state_d = FETCH_REQ;
            endcase
        end
        req_valid_d   = (state_d == FETCH_REQ);
        instr_valid_d = (state_d == FETCH_HOLD);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            misaligned_q  <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            misaligned_q  <= misaligned_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req_valid   = req_valid_q;
    assign imem_req_addr    = pc_q;
    assign instr_valid      = instr_valid_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: transaction-level model compared every cycle plus directed literal checks.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n, branch_resolve, pc_input_sel;
    logic [31:0] alu_result;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        instr_valid, instr_ready, fetch_misaligned;
    logic [31:0] instr, instr_pc;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // memory responder state
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat = 1;
    bit          stray = 1'b0;

    // model state
    logic [31:0] m_pc = RESET_PC, m_instr = 32'h0, m_ipc = 32'h0;
    logic        m_out = 1'b0, m_dead = 1'b0, m_hold = 1'b0, m_halt = 1'b0, m_mis = 1'b0, m_rv = 1'b0;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n), .branch_resolve(branch_resolve), .pc_input_sel(pc_input_sel),
        .alu_result(alu_result), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: one fetch in flight, a dead flag for a redirected fetch, a held instruction slot
    always @(posedge clk) begin : model_p
        logic [31:0] pc, ins, ipc, tgt;
        logic        out, dead, hold, halt, mis, redir, bad;
        pc = m_pc; ins = m_instr; ipc = m_ipc;
        out = m_out; dead = m_dead; hold = m_hold; halt = m_halt; mis = m_mis;
        redir = branch_resolve && (pc_input_sel == 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = alu_result;
        bad = redir && (alu_result[1:0] != 2'b00);
`else
        tgt = {alu_result[31:2], 2'b00};
        bad = 1'b0;
`endif
        if (!reset_n) begin
            pc = RESET_PC; ins = 32'h0; ipc = 32'h0;
            out = 1'b0; dead = 1'b0; hold = 1'b0; halt = 1'b0; mis = 1'b0;
            m_rv <= 1'b0;
        end else begin
            if (halt) begin
                halt = 1'b1;
            end else if (bad) begin
                halt = 1'b1; mis = 1'b1; hold = 1'b0; out = 1'b0; dead = 1'b0;
            end else if (hold) begin
                if (redir) begin pc = tgt; hold = 1'b0; end
                else if (instr_ready) begin pc = pc + 32'd4; hold = 1'b0; end
            end else if (out) begin
                if (imem_rsp_valid) begin
                    out = 1'b0;
                    if (dead || redir) begin dead = 1'b0; if (redir) pc = tgt; end
                    else begin hold = 1'b1; ins = imem_rsp_data; ipc = pc; end
                end else if (redir) begin
                    dead = 1'b1; pc = tgt;
                end
            end else begin
                if (redir) pc = tgt;
                if (m_rv && imem_req_ready) begin out = 1'b1; dead = redir; end
            end
            m_rv <= !hold && !out && !halt;
        end
        m_pc <= pc; m_instr <= ins; m_ipc <= ipc;
        m_out <= out; m_dead <= dead; m_hold <= hold; m_halt <= halt; m_mis <= mis;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model req_valid", {31'b0, imem_req_valid}, {31'b0, m_rv});
            chk("model req_addr", imem_req_addr, m_pc);
            chk("model instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
            chk("model instr", instr, m_instr);
            chk("model instr_pc", instr_pc, m_ipc);
            chk("model misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
        end
    end

    task automatic tick();
        if (stray) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0; stray = 1'b0;
        end else if (pend && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = memf(pend_addr); pend = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
            if (pend) pend_cnt--;
        end
        if (!reset_n) pend = 1'b0;
        else if (imem_req_valid && imem_req_ready) begin
            pend = 1'b1; pend_cnt = lat - 1; pend_addr = imem_req_addr;
        end
        @(posedge clk);
        @(negedge clk);
        branch_resolve = 1'b0;
    endtask

    task automatic redir(input logic [31:0] t);
        branch_resolve = 1'b1; pc_input_sel = 1'b1; alu_result = t;
    endtask

    task automatic wait_hold(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        chk({tag, " hold reached"}, {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pcs[$];
        logic [31:0] dats[$];
        reset_n = 1'b0; branch_resolve = 1'b0; pc_input_sel = 1'b0; alu_result = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        tick(); tick();
        chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst req_addr", imem_req_addr, RESET_PC);
        chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst misaligned", {31'b0, fetch_misaligned}, 32'd0);

        // sequential fetch
        reset_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        chk("first req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (instr_valid && instr_ready) begin pcs.push_back(instr_pc); dats.push_back(instr); end
            tick();
        end
        chk("seq count", pcs.size(), 32'd3);
        if (pcs.size() == 3) begin
            chk("seq pc0", pcs[0], 32'h0); chk("seq pc1", pcs[1], 32'h4); chk("seq pc2", pcs[2], 32'h8);
            chk("seq d0", dats[0], 32'h1357_9BDF); chk("seq d1", dats[1], 32'h1357_9BDB);
            chk("seq d2", dats[2], 32'h1357_9BD7);
        end
        chk("seq next addr", imem_req_addr, 32'hC);

        // decode stall
        instr_ready = 1'b0;
        wait_hold("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall instr", instr, 32'h1357_9BD3);
            chk("stall instr_pc", instr_pc, 32'hC);
            chk("stall instr_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall no req", {31'b0, imem_req_valid}, 32'd0);
        end

        // branch resolved as pc+4 is ignored
        branch_resolve = 1'b1; pc_input_sel = 1'b0; alu_result = 32'h700;
        tick();
        chk("plus4 instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("plus4 instr_pc", instr_pc, 32'hC);

        // redirect beats instr_ready in hold
        redir(32'h200); instr_ready = 1'b1;
        tick();
        chk("hold redir instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("hold redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("hold redir addr", imem_req_addr, 32'h200);

        // redirect while waiting: stale response dropped
        lat = 3;
        tick();
        redir(32'h100);
        tick(); tick(); tick();
        chk("wait redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wait redir addr", imem_req_addr, 32'h100);
        chk("wait redir instr_valid", {31'b0, instr_valid}, 32'd0);
        lat = 1;
        wait_hold("wait redir");
        chk("wait redir instr_pc", instr_pc, 32'h100);
        chk("wait redir instr", instr, 32'h1357_9ADF);
        tick();

        // redirect coincident with the response
        tick();
        redir(32'h300);
        tick();
        chk("rsp redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rsp redir addr", imem_req_addr, 32'h300);
        chk("rsp redir instr_valid", {31'b0, instr_valid}, 32'd0);

        // redirect coincident with the request handshake
        redir(32'h400);
        tick();
        chk("hs redir req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("hs redir req_valid2", {31'b0, imem_req_valid}, 32'd1);
        chk("hs redir addr", imem_req_addr, 32'h400);
        wait_hold("hs redir");
        chk("hs redir instr_pc", instr_pc, 32'h400);
        chk("hs redir instr", instr, 32'h1357_9FDF);
        tick();

        // redirect in request state without handshake
        imem_req_ready = 1'b0;
        redir(32'h500);
        tick();
        chk("req redir req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req redir addr", imem_req_addr, 32'h500);

        // PC wrap at top of address space
        redir(32'hFFFF_FFFC);
        tick();
        chk("wrap addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_hold("wrap");
        chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap next req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wrap next addr", imem_req_addr, 32'h0);

        // misaligned redirect target
        imem_req_ready = 1'b0;
        redir(32'h102);
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("misalign req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b1;
        tick(); tick(); tick();
        chk("halt req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("halt instr_valid", {31'b0, instr_valid}, 32'd0);
`else
        chk("misalign flag", {31'b0, fetch_misaligned}, 32'd0);
        chk("misalign req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("misalign addr", imem_req_addr, 32'h100);
`endif

        // reset mid-transaction, stray response right after release
        imem_req_ready = 1'b1; lat = 3;
        tick();
        reset_n = 1'b0;
        tick(); tick();
        chk("midrst req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midrst addr", imem_req_addr, RESET_PC);
        chk("midrst misaligned", {31'b0, fetch_misaligned}, 32'd0);
        reset_n = 1'b1; lat = 1;
        tick();
        chk("rel req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rel addr", imem_req_addr, RESET_PC);
        stray = 1'b1;
        tick();
        chk("stray ignored", {31'b0, instr_valid}, 32'd0);
        wait_hold("post rst");
        chk("post rst instr_pc", instr_pc, 32'h0);
        chk("post rst instr", instr, 32'h1357_9BDF);
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
